frenzy_coin_seq: RTL

Input sequencer between the keyboard/joystick decode and the game core's coin and start inputs. It turns short or held player requests into coin and start pulses of guaranteed width and spacing. It also serialises competing requests, so the core never sees overlapping coin/start edges. In auto-coin mode, each start request is preceded by a coin pulse.

---
 rtl/frenzy_input_pkg.sv | 28 ++
 rtl/req_latch.sv | 43 ++++
 rtl/frenzy_coin_seq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/frenzy_input_pkg.sv
// Shared types and defaults for the coin/start input sequencer.
package frenzy_input_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COIN  = 3'd1,
        ST_GAP   = 3'd2,
        ST_START = 3'd3,
        ST_HOLD  = 3'd4
    } state_t;

    typedef enum logic {
        SEL_S1 = 1'b0,
        SEL_S2 = 1'b1
    } sel_t;

    localparam int unsigned DEF_COIN_CYCLES  = 32'd4_000_000;
    localparam int unsigned DEF_START_CYCLES = 32'd2_000_000;
    localparam int unsigned DEF_GAP_CYCLES   = 32'd2_000_000;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/req_latch.sv
// Rising-edge detector feeding a sticky pending bit; a held-through-reset
// request does not fire because both history stages reset high.
module req_latch (
    input  logic clk_sys,
    input  logic reset,
    input  logic i_req,
    input  logic i_clr,
    output logic o_pend
);

    logic r_samp;
    logic r_hist;
    logic r_pend;
    logic w_rise;

    assign w_rise = r_samp & ~r_hist;
    assign o_pend = r_pend;

    // Sample the raw level and keep one cycle of history for edge detection.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_samp <= 1'b1;
            r_hist <= 1'b1;
        end else begin
            r_samp <= i_req;
            r_hist <= r_samp;
        end
    end

    // A fresh edge wins over a clear issued in the same cycle.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_pend <= 1'b0;
        end else if (w_rise) begin
            r_pend <= 1'b1;
        end else if (i_clr) begin
            r_pend <= 1'b0;
        end else begin
            r_pend <= r_pend;
        end
    end

endmodule

// File: rtl/frenzy_coin_seq.sv
// Serialises coin/start requests into fixed-width, fixed-spacing pulses,
// optionally prefixing every start with a coin pulse.
module frenzy_coin_seq
    import frenzy_input_pkg::*;
#(
    parameter int unsigned COIN_CYCLES  = DEF_COIN_CYCLES,
    parameter int unsigned START_CYCLES = DEF_START_CYCLES,
    parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic auto_coin,
    input  logic coin1_req,
    input  logic coin2_req,
    input  logic start1_req,
    input  logic start2_req,
    output logic coin1,
    output logic start1,
    output logic start2,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(max3(COIN_CYCLES, START_CYCLES, GAP_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] COIN_LOAD  = CNT_W'(COIN_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 32'd1);

    logic             w_coin_req;
    logic             w_pend_coin, w_pend_s1, w_pend_s2;
    logic             w_clr_coin, w_clr_s1, w_clr_s2;
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    sel_t             r_sel, w_sel_nxt;
    logic             r_lat, w_lat_nxt;
    logic             w_coin1_nxt, w_start1_nxt, w_start2_nxt, w_busy_nxt;

    assign w_coin_req = coin1_req | coin2_req;

    req_latch u_coin (.clk_sys(clk_sys), .reset(reset), .i_req(w_coin_req),
                      .i_clr(w_clr_coin), .o_pend(w_pend_coin));
    req_latch u_s1   (.clk_sys(clk_sys), .reset(reset), .i_req(start1_req),
                      .i_clr(w_clr_s1), .o_pend(w_pend_s1));
    req_latch u_s2   (.clk_sys(clk_sys), .reset(reset), .i_req(start2_req),
                      .i_clr(w_clr_s2), .o_pend(w_pend_s2));

    // State, shared down-counter, start selection and "start follows" flag.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sel   <= SEL_S1;
            r_lat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_lat   <= w_lat_nxt;
        end
    end

    // Arbitration in IDLE (coin > start1 > start2) and timed state exits.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_lat_nxt   = r_lat;
        w_clr_coin  = 1'b0;
        w_clr_s1    = 1'b0;
        w_clr_s2    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pend_coin) begin
                    w_state_nxt = ST_COIN;
                    w_cnt_nxt   = COIN_LOAD;
                    w_lat_nxt   = 1'b0;
                    w_clr_coin  = 1'b1;
                end else if (w_pend_s1 || w_pend_s2) begin
                    w_sel_nxt = w_pend_s1 ? SEL_S1 : SEL_S2;
                    w_clr_s1  = w_pend_s1;
                    w_clr_s2  = ~w_pend_s1;
                    if (auto_coin) begin
                        w_state_nxt = ST_COIN;
                        w_cnt_nxt   = COIN_LOAD;
                        w_lat_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ST_START;
                        w_cnt_nxt   = START_LOAD;
                        w_lat_nxt   = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            ST_COIN: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = GAP_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    if (r_lat) begin
                        w_state_nxt = ST_START;
                        w_cnt_nxt   = START_LOAD;
                        w_lat_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_START: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = GAP_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_lat_nxt   = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registers track the state exactly.
    always_comb begin
        w_coin1_nxt  = (w_state_nxt == ST_COIN);
        w_busy_nxt   = (w_state_nxt != ST_IDLE);
        w_start1_nxt = 1'b0;
        w_start2_nxt = 1'b0;
        if (w_state_nxt == ST_START) begin
            w_start1_nxt = (w_sel_nxt == SEL_S1);
            w_start2_nxt = (w_sel_nxt == SEL_S2);
        end else begin
            w_start1_nxt = 1'b0;
            w_start2_nxt = 1'b0;
        end
    end

    // Registered pulse outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            coin1  <= 1'b0;
            start1 <= 1'b0;
            start2 <= 1'b0;
            busy   <= 1'b0;
        end else begin
            coin1  <= w_coin1_nxt;
            start1 <= w_start1_nxt;
            start2 <= w_start2_nxt;
            busy   <= w_busy_nxt;
        end
    end

endmodule
